// File: rtl/height_digit_renderer.sv
// Binary height -> BCD (double dabble) and glyph-ROM text box overlay on the pixel stream.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (rightmost always shown).
module height_digit_renderer #(
    parameter int              VAL_W      = 10,
    parameter int              NUM_DIGITS = 3,
    parameter int              X0         = 16,
    parameter int              Y0         = 16,
    parameter int              GLYPH_W    = 8,
    parameter int              GLYPH_H    = 16,
    parameter logic [5:0]      BG_COLOR   = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] height_val,
    input  logic             height_valid,
    input  logic             frame_start,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic             pix_active,
    output logic [4:0]       glyph_col,
    output logic [4:0]       glyph_row,
    output logic [3:0]       glyph_digit,
    input  logic [5:0]       glyph_data,
    output logic [5:0]       pixel_out,
    output logic             pixel_valid,
    output logic             conv_busy
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          MAX_VAL = 10 ** NUM_DIGITS - 1;
    localparam int          CNT_W   = $clog2(VAL_W + 1);
    localparam logic [9:0]  X0_10   = 10'(X0);
    localparam logic [9:0]  Y0_10   = 10'(Y0);
    localparam logic [10:0] X1_11   = 11'(X0 + NUM_DIGITS * GLYPH_W);
    localparam logic [10:0] Y1_11   = 11'(Y0 + GLYPH_H);
    localparam logic [9:0]  GW_10   = 10'(GLYPH_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_e;

    conv_state_e       state_q, state_d;
    logic              pending_q, pending_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d;
    logic [VAL_W-1:0]  bin_work_q, bin_work_d;
    logic [BCD_W-1:0]  bcd_work_q, bcd_work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_next_q, bcd_next_d;
    logic [BCD_W-1:0]  bcd_disp_q, bcd_disp_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;

    logic              in_box_q, in_box_d;
    logic              active1_q, active1_d;
    logic              blank1_q, blank1_d;
    logic [4:0]        glyph_col_q, glyph_col_d;
    logic [4:0]        glyph_row_q, glyph_row_d;
    logic [3:0]        glyph_digit_q, glyph_digit_d;
    logic [5:0]        pixel_out_q, pixel_out_d;
    logic              pixel_valid_q, pixel_valid_d;

    logic [VAL_W-1:0]  src_val;
    logic [BCD_W-1:0]  bcd_adj;
    logic [9:0]        dx;
    logic [9:0]        idx_full;

    function automatic logic [VAL_W-1:0] saturate(input logic [VAL_W-1:0] v);
        if (32'(v) > 32'(MAX_VAL)) return VAL_W'(MAX_VAL);
        return v;
    endfunction

    // height_valid is a bare strobe with no ready: it always lands in the pending
    // register (last strobe wins) unless the idle FSM consumes it in the same cycle.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_val_d = pend_val_q;
        bin_work_d = bin_work_q;
        bcd_work_d = bcd_work_q;
        cnt_d      = cnt_q;
        bcd_next_d = bcd_next_q;
        src_val    = height_valid ? height_val : pend_val_q;
        bcd_adj    = bcd_work_q;

        if (height_valid) begin
            pending_d  = 1'b1;
            pend_val_d = height_val;
        end

        case (state_q)
            S_IDLE: begin
                if (height_valid || pending_q) begin
                    bin_work_d = saturate(src_val);
                    bcd_work_d = '0;
                    cnt_d      = '0;
                    pending_d  = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (bcd_work_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work_q[4*i +: 4] + 4'd3;
                end
                {bcd_work_d, bin_work_d} = {bcd_adj, bin_work_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                bcd_next_d = bcd_work_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame latch reads bcd_next_d so a result finishing on the frame_start cycle is shown.
    always_comb begin
        bcd_disp_d = bcd_disp_q;
        blank_d    = blank_q;
        if (frame_start) begin
            bcd_disp_d = bcd_next_d;
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 0; i < NUM_DIGITS; i++) begin
                blank_d[i] = (i == 0) ? 1'b1 : blank_d[i-1];
                if (bcd_next_d[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) blank_d[i] = 1'b0;
            end
            blank_d[NUM_DIGITS-1] = 1'b0;
`else
            blank_d = '0;
`endif
        end
    end

    always_comb begin
        dx            = pix_x - X0_10;
        idx_full      = dx / GW_10;
        active1_d     = pix_active;
        in_box_d      = pix_active && (pix_x >= X0_10) && ({1'b0, pix_x} < X1_11) &&
                        (pix_y >= Y0_10) && ({1'b0, pix_y} < Y1_11);
        glyph_col_d   = '0;
        glyph_row_d   = '0;
        glyph_digit_d = '0;
        blank1_d      = 1'b0;
        if (in_box_d) begin
            glyph_col_d = 5'(dx % GW_10);
            glyph_row_d = 5'(pix_y - Y0_10);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_full == 10'(i)) begin
                    glyph_digit_d = bcd_disp_q[4*(NUM_DIGITS-1-i) +: 4];
                    blank1_d      = blank_q[i];
                end
            end
        end
    end

    always_comb begin
        pixel_valid_d = active1_q;
        if (in_box_q && !blank1_q) pixel_out_d = glyph_data;
        else if (active1_q)        pixel_out_d = BG_COLOR;
        else                       pixel_out_d = 6'b000000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b0;
            pend_val_q    <= '0;
            bin_work_q    <= '0;
            bcd_work_q    <= '0;
            cnt_q         <= '0;
            bcd_next_q    <= '0;
            bcd_disp_q    <= '0;
            blank_q       <= '0;
            in_box_q      <= 1'b0;
            active1_q     <= 1'b0;
            blank1_q      <= 1'b0;
            glyph_col_q   <= '0;
            glyph_row_q   <= '0;
            glyph_digit_q <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pend_val_q    <= pend_val_d;
            bin_work_q    <= bin_work_d;
            bcd_work_q    <= bcd_work_d;
            cnt_q         <= cnt_d;
            bcd_next_q    <= bcd_next_d;
            bcd_disp_q    <= bcd_disp_d;
            blank_q       <= blank_d;
            in_box_q      <= in_box_d;
            active1_q     <= active1_d;
            blank1_q      <= blank1_d;
            glyph_col_q   <= glyph_col_d;
            glyph_row_q   <= glyph_row_d;
            glyph_digit_q <= glyph_digit_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign glyph_col   = glyph_col_q;
    assign glyph_row   = glyph_row_q;
    assign glyph_digit = glyph_digit_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign conv_busy   = (state_q == S_SHIFT);

endmodule

// File: tb/tb_height_digit_renderer.sv
// Scoreboard bench for height_digit_renderer: directed conversions, frame latching and pixel boxes.
module tb_height_digit_renderer;
    localparam int X0 = 16;
    localparam int Y0 = 16;
    localparam int GW = 8;
    localparam int GH = 16;
    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] height_val = '0;
    logic       height_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_active = 1'b0;
    logic [4:0] glyph_col;
    logic [4:0] glyph_row;
    logic [3:0] glyph_digit;
    logic [5:0] glyph_data;
    logic [5:0] pixel_out;
    logic       pixel_valid;
    logic       conv_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_disp[ND];

    logic [13:0] exp_glyph_q[$];
    logic [6:0]  exp_q[$];
    logic        iss_now = 1'b0;
    logic        iss_d1  = 1'b0;
    logic        iss_d2  = 1'b0;

    height_digit_renderer dut (
        .clk(clk), .reset(reset), .height_val(height_val), .height_valid(height_valid),
        .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .glyph_col(glyph_col), .glyph_row(glyph_row), .glyph_digit(glyph_digit),
        .glyph_data(glyph_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .conv_busy(conv_busy)
    );

    // Stand-in glyph ROM: distinct pattern per digit/col/row.
    function automatic logic [5:0] rom(input logic [4:0] c, input logic [4:0] r, input logic [3:0] d);
        return {d, 2'b00} ^ {1'b0, c} ^ {r, 1'b0};
    endfunction

    assign glyph_data = rom(glyph_col, glyph_row, glyph_digit);

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got no end, required end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: stage-1 addresses one cycle after issue, pixel two cycles after
    always @(posedge clk) begin
        iss_d1 <= iss_now;
        iss_d2 <= iss_d1;
    end

    always @(negedge clk) begin
        logic [13:0] eg;
        logic [6:0]  ep;
        if (iss_d1) begin
            if (exp_glyph_q.size() == 0) check("glyph_queue_underflow", 1, 0);
            else begin
                eg = exp_glyph_q.pop_front();
                check("glyph_col", int'(glyph_col), int'(eg[13:9]));
                check("glyph_row", int'(glyph_row), int'(eg[8:4]));
                check("glyph_digit", int'(glyph_digit), int'(eg[3:0]));
            end
        end
        if (iss_d2) begin
            if (exp_q.size() == 0) check("pixel_queue_underflow", 1, 0);
            else begin
                ep = exp_q.pop_front();
                check("pixel_valid", int'(pixel_valid), int'(ep[6]));
                check("pixel_out", int'(pixel_out), int'(ep[5:0]));
            end
        end
    end

    // driver tasks
    task automatic drive(input logic hv, input int hval, input logic fs);
        @(posedge clk); #1;
        iss_now      = 1'b0;
        pix_active   = 1'b0;
        height_valid = hv;
        height_val   = 10'(hval);
        frame_start  = fs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic set_disp(input int d0, input int d1, input int d2);
        exp_disp[0] = d0; exp_disp[1] = d1; exp_disp[2] = d2;
    endtask

    task automatic pix(input int x, input int y, input logic act);
        int idx, col, row, dig;
        logic in_box, blank;
        logic [5:0] p;
        in_box = act && x >= X0 && x < X0 + ND*GW && y >= Y0 && y < Y0 + GH;
        idx = 0; col = 0; row = 0; dig = 0; blank = 1'b0;
        if (in_box) begin
            idx = (x - X0) / GW;
            col = (x - X0) % GW;
            row = y - Y0;
            dig = exp_disp[idx];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (idx != ND-1);
            for (int i = 0; i <= idx; i++) if (exp_disp[i] != 0) blank = 1'b0;
`endif
        end
        p = (in_box && !blank) ? rom(5'(col), 5'(row), 4'(dig)) : (act ? 6'h3f : 6'h00);
        exp_glyph_q.push_back({5'(col), 5'(row), 4'(dig)});
        exp_q.push_back({act, p});
        @(posedge clk); #1;
        pix_x = 10'(x); pix_y = 10'(y); pix_active = act;
        height_valid = 1'b0; frame_start = 1'b0;
        iss_now = 1'b1;
    endtask

    // Fixed probe table: inside each digit, box edges, just outside, inactive.
    task automatic render();
        int ox[11] = '{0, 9, 23, 13, 17, 4, 24, -1, 5, 5, 9};
        int oy[11] = '{0, 1, 15, 7, 4, 9, 0, 3, -1, 16, 1};
        for (int i = 0; i < 11; i++) pix(X0 + ox[i], Y0 + oy[i], i != 10);
        idle(3);
    endtask

    // Strobe at cycle 0, frame_start optionally at cycle fs_cycle; busy expected on cycles 1..10.
    task automatic conv_run(input int v, input int fs_cycle);
        for (int c = 0; c < 12; c++) begin
            drive(c == 0, v, c == fs_cycle);
            @(negedge clk);
            check("conv_busy", int'(conv_busy), (c >= 1 && c <= 10) ? 1 : 0);
        end
        idle(1);
    endtask

    task automatic check_all_zero();
        check("rst_glyph_col", int'(glyph_col), 0);
        check("rst_glyph_row", int'(glyph_row), 0);
        check("rst_glyph_digit", int'(glyph_digit), 0);
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_pixel_valid", int'(pixel_valid), 0);
        check("rst_conv_busy", int'(conv_busy), 0);
    endtask

    initial begin
        set_disp(0, 0, 0);
        repeat (3) @(negedge clk);
        check_all_zero();
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        render();                      // "000" straight out of reset
        conv_run(173, 11);             // frame_start coincides with DONE: bypass
        set_disp(1, 7, 3);
        render();

        conv_run(1023, 10);            // frame_start one cycle early keeps 173
        render();
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(9, 9, 9);
        render();

        conv_run(42, -1);              // mid-frame update must not show
        render();
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(0, 4, 2);
        render();

        drive(1'b1, 100, 1'b0); idle(2);   // later strobes while busy; last one wins
        drive(1'b1, 250, 1'b0); idle(1);
        drive(1'b1, 321, 1'b0); idle(40);
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(3, 2, 1);
        render();

        drive(1'b1, 300, 1'b0); idle(10);  // second strobe lands on the DONE cycle
        drive(1'b1, 7, 1'b0); idle(30);
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(0, 0, 7);
        render();

        drive(1'b1, 5, 1'b0); idle(20);
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(0, 0, 5);
        render();

        drive(1'b1, 0, 1'b0); idle(20);
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(0, 0, 0);
        render();

        drive(1'b1, 506, 1'b0); idle(20);
        drive(1'b0, 0, 1'b1); idle(1);
        set_disp(5, 0, 6);
        render();

        // Mid-frame reset during a conversion with another value pending
        drive(1'b1, 555, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            height_valid = (i == 1); height_val = 10'd888;
            pix_x = 10'(X0 + 9); pix_y = 10'(Y0 + 1); pix_active = 1'b1;
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_all_zero();
        @(posedge clk); #1;
        height_valid = 1'b0; pix_active = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(25);
        check("post_reset_busy", int'(conv_busy), 0);
        set_disp(0, 0, 0);
        render();
        drive(1'b0, 0, 1'b1); idle(1);
        render();

        idle(3);
        check("glyph_queue_drained", exp_glyph_q.size(), 0);
        check("pixel_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
